// File: rtl/exec_pkg.sv
// Shared definitions for the execute unit: opcodes, FSM states,
// result-flag indices and instruction field positions.
package exec_pkg;

   localparam logic [5:0] OP_LDI  = 6'h00;
   localparam logic [5:0] OP_MOV  = 6'h01;
   localparam logic [5:0] OP_LD   = 6'h02;
   localparam logic [5:0] OP_ST   = 6'h03;
   localparam logic [5:0] OP_ADD  = 6'h04;
   localparam logic [5:0] OP_SUB  = 6'h05;
   localparam logic [5:0] OP_NEG  = 6'h06;
   localparam logic [5:0] OP_MUL  = 6'h07;
   localparam logic [5:0] OP_DIV  = 6'h08;
   localparam logic [5:0] OP_OR   = 6'h09;
   localparam logic [5:0] OP_XOR  = 6'h0A;
   localparam logic [5:0] OP_NAND = 6'h0B;
   localparam logic [5:0] OP_NOR  = 6'h0C;
   localparam logic [5:0] OP_XNOR = 6'h0D;
   localparam logic [5:0] OP_NOT  = 6'h0E;
   localparam logic [5:0] OP_SHL  = 6'h0F;
   localparam logic [5:0] OP_SHR  = 6'h10;

   typedef enum logic [1:0] {IDLE, ITER, RESP} state_t;

   localparam int F_ZERO  = 0;
   localparam int F_CARRY = 1;
   localparam int F_DZ    = 2;
   localparam int F_ILL   = 3;

   localparam int OPC_LSB = 26;
   localparam int RD_LSB  = 21;
   localparam int RS1_LSB = 16;
   localparam int RS2_LSB = 11;

endpackage

// File: rtl/exec_unit_p_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider.
// hi/lo present the value the current step will produce; done marks the last step.
module seq_muldiv #(
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   input  logic          op,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   output logic          done,
   output logic [DW-1:0] hi,
   output logic [DW-1:0] lo
);
   localparam int CW = $clog2(DW);

   logic              r_busy;
   logic              r_op;
   logic [DW-1:0]     r_b;
   logic [2*DW-1:0]   r_p;
   logic [CW-1:0]     r_cnt;
   logic [DW:0]       w_sum;
   logic [DW:0]       w_t;
   logic [DW:0]       w_diff;
   logic [2*DW-1:0]   w_next;

   // r_p holds {acc, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      w_sum  = {1'b0, r_p[2*DW-1:DW]} + (r_p[0] ? {1'b0, r_b} : '0);
      w_t    = {r_p[2*DW-1:DW], r_p[DW-1]};
      w_diff = w_t - {1'b0, r_b};
      if (r_op)
         w_next = w_diff[DW] ? {w_t[DW-1:0], r_p[DW-2:0], 1'b0}
                             : {w_diff[DW-1:0], r_p[DW-2:0], 1'b1};
      else
         w_next = {w_sum, r_p[DW-1:1]};
   end

   assign done = r_busy && (r_cnt == CW'(DW - 1));
   assign hi   = w_next[2*DW-1:DW];
   assign lo   = w_next[DW-1:0];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_op   <= 1'b0;
         r_b    <= '0;
         r_p    <= '0;
         r_cnt  <= '0;
      end else if (start) begin
         r_busy <= 1'b1;
         r_op   <= op;
         r_b    <= b;
         r_p    <= {{DW{1'b0}}, a};
         r_cnt  <= '0;
      end else if (r_busy) begin
         r_p   <= w_next;
         r_cnt <= r_cnt + 1'b1;
         if (done) r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/exec_unit_p.sv
// Execute unit: decode, ALU, register file and data memory with
// valid/ready instruction and result handshakes.
module exec_unit_p
   import exec_pkg::*;
#(
   parameter int DW = 8,
   parameter int RA = 5,
   parameter int DA = 8
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            instr_valid,
   output logic            instr_ready,
   input  logic [31:0]     instruction,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [2*DW-1:0] res,
   output logic [3:0]      res_flags,
   input  logic [RA-1:0]   dbg_addr,
   output logic [DW-1:0]   dbg_data
);
   localparam int SW = $clog2(DW);
   localparam int NR = 2**RA;

   state_t            r_state, w_state_nx;
   logic [DW-1:0]     r_rf  [NR];
   logic [DW-1:0]     r_mem [2**DA];
   logic [RA-1:0]     r_rd;
   logic [2*DW-1:0]   r_res;
   logic [3:0]        r_flags;

   logic [5:0]        w_opc;
   logic [RA-1:0]     w_rd, w_rs1, w_rs2;
   logic [DA-1:0]     w_addr;
   logic [DW-1:0]     w_a, w_b, w_imm, w_val, w_hi, w_lo;
   logic [DW:0]       w_wide;
   logic              w_carry, w_ill, w_is_md, w_dz, w_accept;
   logic              w_start, w_md_done, w_fin, w_load, w_mem_we;
   logic              w_we0, w_we1;
   logic [RA-1:0]     w_wa0, w_wa1;
   logic [DW-1:0]     w_wd0, w_wd1;
   logic [2*DW-1:0]   w_res_nx;
   logic [3:0]        w_flags_nx;
   logic              w_unused;

   assign w_opc    = instruction[OPC_LSB +: 6];
   assign w_rd     = instruction[RD_LSB +: RA];
   assign w_rs1    = instruction[RS1_LSB +: RA];
   assign w_rs2    = instruction[RS2_LSB +: RA];
   assign w_imm    = DW'(instruction[10:0]);
   assign w_addr   = instruction[DA-1:0];
   assign w_unused = ^instruction;
   assign w_a      = r_rf[w_rs1];
   assign w_b      = r_rf[w_rs2];

   assign w_is_md  = (w_opc == OP_MUL) || (w_opc == OP_DIV);
   assign w_dz     = (w_opc == OP_DIV) && (w_b == '0);
   assign w_accept = (r_state == IDLE) && instr_valid;
   assign w_start  = w_accept && w_is_md && !w_dz;
   assign w_fin    = (r_state == ITER) && w_md_done;
   assign w_mem_we = w_accept && (w_opc == OP_ST) && !reset;

   always_comb begin
      w_val   = '0;
      w_wide  = '0;
      w_carry = 1'b0;
      w_ill   = 1'b0;
      unique case (w_opc)
         OP_LDI:  w_val = w_imm;
         OP_MOV:  w_val = w_a;
         OP_LD:   w_val = r_mem[w_addr];
         OP_ST:   w_val = w_a;
         OP_ADD: begin
            w_wide  = {1'b0, w_a} + {1'b0, w_b};
            w_val   = w_wide[DW-1:0];
            w_carry = w_wide[DW];
         end
         OP_SUB: begin
            w_wide  = {1'b0, w_a} - {1'b0, w_b};
            w_val   = w_wide[DW-1:0];
            w_carry = w_wide[DW];
         end
         OP_NEG:  w_val = -w_a;
         // all-ones doubles as the divide-by-zero quotient
         OP_MUL, OP_DIV: w_val = '1;
         OP_OR:   w_val = w_a | w_b;
         OP_XOR:  w_val = w_a ^ w_b;
         OP_NAND: w_val = ~(w_a & w_b);
         OP_NOR:  w_val = ~(w_a | w_b);
         OP_XNOR: w_val = ~(w_a ^ w_b);
         OP_NOT:  w_val = ~w_a;
         OP_SHL:  w_val = w_a << w_b[SW-1:0];
         OP_SHR:  w_val = w_a >> w_b[SW-1:0];
         default: w_ill = 1'b1;
      endcase
   end

   seq_muldiv #(.DW(DW)) u_muldiv (
      .clk   (clk),
      .reset (reset),
      .start (w_start),
      .op    (w_opc == OP_DIV),
      .a     (w_a),
      .b     (w_b),
      .done  (w_md_done),
      .hi    (w_hi),
      .lo    (w_lo)
   );

   always_comb begin
      w_we0 = 1'b0;
      w_we1 = 1'b0;
      w_wa0 = w_rd;
      w_wa1 = w_rd + 1'b1;
      w_wd0 = w_val;
      w_wd1 = w_a;
      if (w_accept && !w_ill) begin
         if (w_dz) begin
            w_we0 = 1'b1;
            w_we1 = 1'b1;
         end else if (!w_is_md && (w_opc != OP_ST)) begin
            w_we0 = 1'b1;
         end
      end
      if (w_fin) begin
         w_we0 = 1'b1;
         w_we1 = 1'b1;
         w_wa0 = r_rd;
         w_wa1 = r_rd + 1'b1;
         w_wd0 = w_lo;
         w_wd1 = w_hi;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      unique case (r_state)
         IDLE: if (instr_valid)
                  w_state_nx = (w_is_md && !w_dz) ? ITER : RESP;
         ITER: if (w_md_done) w_state_nx = RESP;
         RESP: if (res_ready) w_state_nx = IDLE;
         default: w_state_nx = IDLE;
      endcase
   end

   always_comb begin
      w_res_nx   = '0;
      w_flags_nx = '0;
      if (r_state == ITER) begin
         w_res_nx           = {w_hi, w_lo};
         w_flags_nx[F_ZERO] = ({w_hi, w_lo} == '0);
      end else if (w_dz) begin
         w_res_nx           = {w_a, w_val};
         w_flags_nx[F_DZ]   = 1'b1;
      end else begin
         w_res_nx            = {{DW{1'b0}}, w_val};
         w_flags_nx[F_ILL]   = w_ill;
         w_flags_nx[F_CARRY] = w_carry;
         w_flags_nx[F_ZERO]  = !w_ill && (w_val == '0);
      end
   end

   assign w_load = (r_state != RESP) && (w_state_nx == RESP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_rd    <= '0;
         r_res   <= '0;
         r_flags <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) r_rd <= w_rd;
         if (w_load) begin
            r_res   <= w_res_nx;
            r_flags <= w_flags_nx;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NR; i++) r_rf[i] <= '0;
      end else begin
         if (w_we0) r_rf[w_wa0] <= w_wd0;
         if (w_we1) r_rf[w_wa1] <= w_wd1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_mem_we) r_mem[w_addr] <= w_a;
   end

   assign instr_ready = (r_state == IDLE);
   assign res_valid   = (r_state == RESP);
   assign res         = r_res;
   assign res_flags   = r_flags;
   assign dbg_data    = r_rf[dbg_addr];

endmodule

// File: tb/tb_exec_unit_p.sv
// Directed bench for exec_unit_p (DW=8) against an arithmetic
// reference model of the instruction set.
module tb_exec_unit_p;

   logic        clk = 1'b0;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instruction;
   logic        res_valid;
   logic        res_ready;
   logic [15:0] res;
   logic [3:0]  res_flags;
   logic [4:0]  dbg_addr;
   logic [7:0]  dbg_data;

   int checks = 0;
   int failures = 0;
   int m_rf [32];
   int m_mem [256];
   int exp_res, exp_flags, exp_lat;

   exec_unit_p #(.DW(8), .RA(5), .DA(8)) dut (
      .clk         (clk),
      .reset       (reset),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .instruction (instruction),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res         (res),
      .res_flags   (res_flags),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] enc(input int op, rd, rs1, rs2, imm);
      logic [31:0] w;
      w = {op[5:0], rd[4:0], rs1[4:0], rs2[4:0], imm[10:0]};
      return w;
   endfunction

   // Reference model: plain integer arithmetic per instruction
   task automatic model(input int op, rd, rs1, rs2, imm);
      int a, b, r, p;
      bit wr;
      a = m_rf[rs1];
      b = m_rf[rs2];
      r = 0;
      wr = 1;
      exp_lat = 0;
      exp_flags = 0;
      case (op)
         0:  r = imm & 255;
         1:  r = a;
         2:  r = m_mem[imm & 255];
         3:  begin r = a; wr = 0; m_mem[imm & 255] = a; end
         4:  begin r = (a + b) & 255; if (a + b > 255) exp_flags = 2; end
         5:  begin r = (a - b) & 255; if (a < b) exp_flags = 2; end
         6:  r = (256 - a) & 255;
         7, 8: begin
            if (op == 7) p = a * b;
            else if (b == 0) p = a * 256 + 255;
            else p = (a % b) * 256 + (a / b);
            m_rf[rd] = p & 255;
            m_rf[(rd + 1) % 32] = p >> 8;
            exp_res = p;
            if (op == 8 && b == 0) exp_flags = 4;
            else begin
               exp_lat = 8;
               if (p == 0) exp_flags = 1;
            end
            return;
         end
         9:  r = a | b;
         10: r = a ^ b;
         11: r = 255 - (a & b);
         12: r = 255 - (a | b);
         13: r = 255 - (a ^ b);
         14: r = 255 - a;
         15: r = (a << (b % 8)) & 255;
         16: r = a >> (b % 8);
         default: begin exp_res = 0; exp_flags = 8; return; end
      endcase
      if (wr) m_rf[rd] = r;
      exp_res = r;
      if (r == 0) exp_flags = exp_flags | 1;
   endtask

   task automatic issue(input int op, rd, rs1, rs2, imm,
                        input int lit_res, lit_flags, hold);
      int lat;
      model(op, rd, rs1, rs2, imm);
      if (lit_res >= 0) begin
         chk("model_res", exp_res, lit_res);
         chk("model_flags", exp_flags, lit_flags);
      end
      @(negedge clk);
      chk("ready_idle", int'(instr_ready), 1);
      instr_valid = 1'b1;
      instruction = enc(op, rd, rs1, rs2, imm);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      lat = 0;
      while (!res_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      // a competing instruction offered while busy must be ignored
      if (hold > 0) begin
         instr_valid = 1'b1;
         instruction = enc(0, 1, 0, 0, 'h55);
      end
      repeat (hold) begin
         @(posedge clk);
         #1;
         chk("held_valid", int'(res_valid), 1);
      end
      instr_valid = 1'b0;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      res_ready = 1'b0;
      chk("ready_after", int'(instr_ready), 1);
      chk("valid_after", int'(res_valid), 0);
   endtask

   task automatic peek(input int r, input int lit);
      dbg_addr = 5'(r);
      #1;
      chk("dbg_lit", int'(dbg_data), lit);
      chk("model_reg", m_rf[r], lit);
   endtask

   task automatic check_all();
      for (int i = 0; i < 32; i++) begin
         dbg_addr = 5'(i);
         #1;
         chk("rf_all", int'(dbg_data), m_rf[i]);
      end
   endtask

   always @(negedge clk) begin
      if (!reset && res_valid) begin
         chk("res", int'(res), exp_res);
         chk("flags", int'(res_flags), exp_flags);
         chk("ready_busy", int'(instr_ready), 0);
         chk("dbg", int'(dbg_data), m_rf[dbg_addr]);
      end
   end

   initial begin
      reset = 1'b1;
      instr_valid = 1'b0;
      res_ready = 1'b0;
      instruction = '0;
      dbg_addr = '0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      for (int i = 0; i < 256; i++) m_mem[i] = 0;
      #1;
      chk("rst_ready", int'(instr_ready), 1);
      chk("rst_valid", int'(res_valid), 0);
      chk("rst_res", int'(res), 0);
      chk("rst_flags", int'(res_flags), 0);
      repeat (2) @(posedge clk);
      check_all();
      @(negedge clk);
      reset = 1'b0;

      issue(0, 1, 0, 0, 7, 'h0007, 0, 0);
      issue(0, 2, 0, 0, 5, 'h0005, 0, 0);
      dbg_addr = 3;
      issue(4, 3, 1, 2, 0, 'h000C, 0, 0);
      peek(3, 'h0C);
      issue(5, 4, 2, 1, 0, 'h00FE, 2, 0);

      issue(0, 1, 0, 0, 'hFF, 'h00FF, 0, 0);
      issue(0, 2, 0, 0, 'hFF, 'h00FF, 0, 0);
      issue(7, 4, 1, 2, 0, 'hFE01, 0, 0);
      peek(4, 'h01);
      peek(5, 'hFE);

      issue(0, 1, 0, 0, 100, 'h0064, 0, 0);
      issue(0, 2, 0, 0, 7, 'h0007, 0, 0);
      issue(8, 6, 1, 2, 0, 'h020E, 0, 0);
      peek(6, 'h0E);
      peek(7, 'h02);
      issue(0, 9, 0, 0, 0, 'h0000, 1, 0);
      issue(8, 10, 1, 9, 0, 'h64FF, 4, 0);
      peek(10, 'hFF);
      peek(11, 'h64);

      issue(7, 31, 1, 2, 0, 'h02BC, 0, 0);
      peek(31, 'hBC);
      peek(0, 'h02);
      issue(3, 0, 3, 0, 'h40, 'h000C, 0, 0);
      peek(0, 'h02);
      issue(2, 8, 0, 0, 'h40, 'h000C, 0, 0);
      peek(8, 'h0C);

      issue(10, 11, 1, 2, 0, 'h0063, 0, 5);
      peek(1, 'h64);
      issue(5, 12, 1, 1, 0, 'h0000, 1, 0);
      issue(0, 13, 0, 0, 'h80, 'h0080, 0, 0);
      issue(4, 14, 13, 13, 0, 'h0000, 3, 0);
      issue(16, 15, 13, 2, 0, 'h0001, 0, 0);
      issue(15, 16, 1, 2, 0, 'h0000, 1, 0);
      issue(11, 17, 1, 2, 0, 'h00FB, 0, 0);
      issue(6, 18, 2, 0, 0, 'h00F9, 0, 0);
      issue(0, 19, 0, 0, 'h7AB, 'h00AB, 0, 0);
      issue(1, 20, 19, 0, 0, 'h00AB, 0, 0);
      issue(12, 21, 1, 2, 0, 'h0098, 0, 0);
      issue(13, 22, 1, 2, 0, 'h009C, 0, 0);
      issue(9, 23, 1, 2, 0, 'h0067, 0, 0);
      issue(14, 24, 1, 0, 0, 'h009B, 0, 0);
      issue(7, 25, 9, 1, 0, 'h0000, 1, 0);
      issue('h3F, 1, 2, 3, 'h40, 'h0000, 8, 0);
      check_all();

      // reset during the fourth MUL iteration
      @(negedge clk);
      instr_valid = 1'b1;
      instruction = enc(7, 20, 1, 2, 0);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_mid_ready", int'(instr_ready), 1);
      chk("rst_mid_valid", int'(res_valid), 0);
      chk("rst_mid_res", int'(res), 0);
      chk("rst_mid_flags", int'(res_flags), 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_hold_ready", int'(instr_ready), 1);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 32; i++) m_rf[i] = 0;
      repeat (10) @(posedge clk);
      #1;
      chk("rel_ready", int'(instr_ready), 1);
      chk("rel_valid", int'(res_valid), 0);
      check_all();
      issue(0, 1, 0, 0, 3, 'h0003, 0, 0);
      peek(1, 'h03);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/exec_unit_p.md
# exec_unit_p

Parametrised, multi-cycle execute unit for the Harvard processor: decodes a 32-bit instruction and performs register/data-memory moves and ALU operations on a DW-bit datapath. It owns the register file and data memory, and writes results back to them. Valid/ready handshakes on instruction and result; MUL/DIV run iteratively over DW cycles. Sits between instruction fetch/decode and the top-level debug/output logic.

## Interface
- DW, 8: data width (4..11)
- RA, 5: register-file address bits (2^RA registers, RA ≤ 5)
- DA, 8: data-memory address bits (2^DA words, DA ≤ 11)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- instr_valid  in  1  instruction offered
- instr_ready  out  1  unit can accept; reset 1
- instruction  in  32  opcode[31:26], rdst[25:21], rsrc1[20:16], rsrc2[15:11], imm/addr[10:0]
- res_valid  out  1  result available; reset 0
- res_ready  in  1  consumer takes result
- res  out  2*DW  {hi,lo}; reset 0
- res_flags  out  4  {illegal, dz, carry, zero}; reset 0
- dbg_addr  in  RA  debug register select
- dbg_data  out  DW  combinational regfile[dbg_addr]

## Operation
- Register fields use the low RA bits. imm = instruction[10:0] zero-extended/truncated to DW. addr = instruction[DA-1:0].
- Opcodes:
  - 0x00 LDI rd←imm
  - 0x01 MOV rd←rs1
  - 0x02 LD rd←mem[addr]
  - 0x03 ST mem[addr]←rs1; regfile unchanged
  - 0x04 ADD rs1+rs2; carry = carry-out
  - 0x05 SUB rs1−rs2; carry = borrow
  - 0x06 NEG −rs1 (two's complement)
  - 0x07 MUL
  - 0x08 DIV
  - 0x09 OR
  - 0x0A XOR
  - 0x0B NAND
  - 0x0C NOR
  - 0x0D XNOR
  - 0x0E NOT rs1
  - 0x0F SHL rs1<<rs2[$clog2(DW)-1:0]
  - 0x10 SHR rs1>>rs2[$clog2(DW)-1:0] (logical)
  - all others illegal
- Single-result ops: res = {0, result}; rd written with result; LD/MOV/ST return the moved value.
- MUL: unsigned rs1×rs2, 2*DW bits. rd←lo, (rd+1 mod 2^RA)←hi.
- DIV: unsigned rs1/rs2. rd←quotient, (rd+1)←remainder. res = {rem, quot}.
- Divide by zero: quotient all-ones, remainder = rs1, dz=1.
- zero flag: set when the written result (full 2*DW for MUL/DIV) is zero. carry only for ADD/SUB, else 0.
- Illegal opcode: no regfile or memory write; res=0; illegal=1.
- FSM states:
  - IDLE (instr_ready=1): accept on instr_valid. Simple ops → RESP; MUL/DIV with nonzero divisor → ITER; DIV by zero → RESP.
  - ITER: DW iteration cycles. On the last one, write back and → RESP.
  - RESP (res_valid=1): on res_ready → IDLE.
- Operands are read from the register file at accept and latched. Writes land at the accept edge (simple ops) or the final ITER edge.
- Register file is cleared to 0 on reset. Data memory is not reset.
- rd+1 wraps: rd = 2^RA−1 writes hi/rem to register 0.

## Timing
- Simple op accepted at edge k: regfile/memory updated at edge k; res_valid=1 from k+1.
- MUL/DIV accepted at edge k: ITER covers edges k+1..k+DW; writeback and res_valid at edge k+DW.
- DIV by zero: res_valid from k+1.
- res, res_flags and res_valid are held stable while res_valid && !res_ready.
- Handshake at edge m (res_valid && res_ready): instr_ready=1 from m+1. Maximum throughput is one simple op per 2 cycles.
- instr_ready=0 in ITER and RESP; instruction is ignored there.
- Reset asserted at any time: state returns to IDLE immediately, any pending MUL/DIV writeback is dropped, outputs go to reset values.
- dbg_data reflects a write from the edge that performs it.

## Structure
- Package exec_pkg:
  - opcode localparams
  - FSM state enum (IDLE, ITER, RESP)
  - flag bit indices
  - instruction field bit positions
- Sub-module seq_muldiv:
  - parametrised DW; iterative shift-add multiplier / restoring divider
  - start/op/a/b in; done, hi, lo out
  - DW-cycle latency; same clk/reset
- Top holds the FSM, register file, data memory, combinational ALU and writeback mux.

## Test plan
All scenarios use DW=8.
- LDI r1,7; LDI r2,5; ADD r3=r1+r2 → res=0x000C, flags 0, dbg r3=0x0C; SUB r4=r2−r1 → res=0x00FE, carry=1.
- LDI r1,0xFF; LDI r2,0xFF; MUL r4 → res_valid exactly 8 cycles after accept, res=0xFE01, r4=0x01, r5=0xFE.
- DIV 100/7 into r6 → res=0x020E (r6=14, r7=2); DIV 100/0 → res=0x64FF, dz=1, res_valid at k+1.
- MUL with rd=31 → hi written to r0; ST r3→mem[0x40], then LD r8←mem[0x40] → r8=0x0C.
- Hold res_ready=0 for 5 cycles → res/flags stable, instr_ready=0. Opcode 0x3F → illegal=1, res=0, no state change.
- Reset asserted at iteration 4 of MUL → no writeback, all registers 0, instr_ready=1 while reset is high and after release.
